mem_bus_arbiter: RTL and testbench

Sequences and shares the single external memory port between the data cache (refill/write-back traffic) and the uncached LSU path that the memory stage's cacheable-region selection splits load/store traffic into. It accepts one transaction at a time from either requester. Simultaneous requests are resolved round-robin. The block drives a req/ack bus handshake with a watchdog timeout and returns read data with a one-cycle valid pulse to the owning requester.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/arb_timeout_cnt.sv | 30 +++
 rtl/mem_bus_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory bus arbiter: FSM states, the
// transaction owner and the error_o codes reported on a watchdog timeout.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CACHE = 1'b0,
        OWN_LSU   = 1'b1
    } owner_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_CACHE = 2'b01;
    localparam logic [1:0] ERR_LSU   = 2'b10;

    function automatic logic [1:0] timeout_code(input owner_t owner);
        return (owner == OWN_LSU) ? ERR_LSU : ERR_CACHE;
    endfunction

endpackage

// File: rtl/arb_timeout_cnt.sv
// Saturating watchdog counter for the arbiter's BUSY phase. A LIMIT of 0
// disables the watchdog: the count never moves and hit never asserts.
module arb_timeout_cnt #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rstn_i,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    localparam int unsigned CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CW-1:0] MAX = CW'(LIMIT);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign hit = (LIMIT != 0) && (cnt_q == MAX);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single external memory port between the data cache and the
// uncached LSU path: one transaction at a time, round-robin on contention.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rstn_i,

    input  logic        cache_req_i,
    input  logic        cache_we_i,
    input  logic [31:0] cache_addr_i,
    input  logic [31:0] cache_wdata_i,
    output logic        cache_gnt_o,
    output logic        cache_valid_o,
    output logic [31:0] cache_rdata_o,

    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_gnt_o,
    output logic        lsu_valid_o,
    output logic [31:0] lsu_rdata_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,

    output logic [1:0]  error_o
);

    state_t      state_q;
    owner_t      owner_q;
    logic        rr_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic        start;
    logic        pick_lsu;
    logic        busy;
    logic        hit;

    // The pointer only matters under contention; a lone requester always wins.
    always_comb begin
        pick_lsu = lsu_req_i & (~cache_req_i | rr_q);
        start    = rstn_i & (state_q == IDLE) & (cache_req_i | lsu_req_i);
    end

    assign busy        = (state_q == BUSY);
    assign cache_gnt_o = start & ~pick_lsu;
    assign lsu_gnt_o   = start & pick_lsu;

    arb_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rstn_i (rstn_i),
        .clear  (start),
        .enable (busy & ~mem_ack_i),
        .hit    (hit)
    );

    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            owner_q <= OWN_CACHE;
            rr_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= BUSY;
                        owner_q <= pick_lsu ? OWN_LSU : OWN_CACHE;
                        we_q    <= pick_lsu ? lsu_we_i    : cache_we_i;
                        addr_q  <= pick_lsu ? lsu_addr_i  : cache_addr_i;
                        wdata_q <= pick_lsu ? lsu_wdata_i : cache_wdata_i;
                    end
                end
                // An ack in the same cycle as the watchdog hit still wins.
                BUSY: begin
                    if (mem_ack_i) begin
                        rdata_q <= mem_rdata_i;
                        state_q <= RESP;
                    end else if (hit) begin
                        rdata_q <= '0;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    rr_q    <= (owner_q == OWN_CACHE);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req_o   = busy & ~hit;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign error_o     = (busy & hit & ~mem_ack_i) ? timeout_code(owner_q) : ERR_NONE;

    assign cache_valid_o = (state_q == RESP) & (owner_q == OWN_CACHE);
    assign lsu_valid_o   = (state_q == RESP) & (owner_q == OWN_LSU);
    assign cache_rdata_o = cache_valid_o ? rdata_q : '0;
    assign lsu_rdata_o   = lsu_valid_o   ? rdata_q : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed cycle checks plus a
// scoreboard of expected completions popped whenever a valid pulse appears.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        cache_req_i, cache_we_i;
    logic [31:0] cache_addr_i, cache_wdata_i;
    logic        cache_gnt_o, cache_valid_o;
    logic [31:0] cache_rdata_o;
    logic        lsu_req_i, lsu_we_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i;
    logic        lsu_gnt_o, lsu_valid_o;
    logic [31:0] lsu_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [1:0]  error_o;

    typedef struct packed {
        logic        lsu;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk           (clk),
        .rstn_i        (rstn_i),
        .cache_req_i   (cache_req_i),
        .cache_we_i    (cache_we_i),
        .cache_addr_i  (cache_addr_i),
        .cache_wdata_i (cache_wdata_i),
        .cache_gnt_o   (cache_gnt_o),
        .cache_valid_o (cache_valid_o),
        .cache_rdata_o (cache_rdata_o),
        .lsu_req_i     (lsu_req_i),
        .lsu_we_i      (lsu_we_i),
        .lsu_addr_i    (lsu_addr_i),
        .lsu_wdata_i   (lsu_wdata_i),
        .lsu_gnt_o     (lsu_gnt_o),
        .lsu_valid_o   (lsu_valid_o),
        .lsu_rdata_o   (lsu_rdata_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rdata_i   (mem_rdata_i),
        .error_o       (error_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic c_req, input logic c_we, input logic [31:0] c_addr,
                                 input logic [31:0] c_wdata, input logic l_req, input logic l_we,
                                 input logic [31:0] l_addr, input logic [31:0] l_wdata);
        cache_req_i   = c_req;
        cache_we_i    = c_we;
        cache_addr_i  = c_addr;
        cache_wdata_i = c_wdata;
        lsu_req_i     = l_req;
        lsu_we_i      = l_we;
        lsu_addr_i    = l_addr;
        lsu_wdata_i   = l_wdata;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Completion monitor: every valid pulse must match the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (cache_valid_o || lsu_valid_o) begin
            checkOutput("valid_exclusive", {31'd0, cache_valid_o & lsu_valid_o}, 32'd0);
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                checkOutput("valid_owner", {31'd0, lsu_valid_o}, {31'd0, e.lsu});
                checkOutput("valid_rdata", e.lsu ? lsu_rdata_o : cache_rdata_o, e.rdata);
                checkOutput("nonowner_rdata", e.lsu ? cache_rdata_o : lsu_rdata_o, 32'd0);
            end
        end else begin
            checkOutput("idle_rdata", cache_rdata_o | lsu_rdata_o, 32'd0);
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] simulation hang");
    end

    initial begin : stimulus
        logic [31:0] c_addr, l_addr;
        rstn_i      = 1'b0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        applyStimulus(1'b1, 1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, '0, '0);

        // Reset state, including a request that must not be granted in reset.
        next_cycle();
        next_cycle();
        sample();
        checkOutput("rst_cache_gnt", {31'd0, cache_gnt_o}, 32'd0);
        checkOutput("rst_lsu_gnt", {31'd0, lsu_gnt_o}, 32'd0);
        checkOutput("rst_valids", {30'd0, cache_valid_o, lsu_valid_o}, 32'd0);
        checkOutput("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        checkOutput("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr_o, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata_o, 32'd0);
        checkOutput("rst_error", {30'd0, error_o}, 32'd0);
        next_cycle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        rstn_i = 1'b1;
        sample();

        // Lone LSU read, ack two cycles after mem_req rises.
        next_cycle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h1000_0000, '0);
        sample();
        checkOutput("t1_lsu_gnt", {31'd0, lsu_gnt_o}, 32'd1);
        checkOutput("t1_cache_gnt", {31'd0, cache_gnt_o}, 32'd0);
        sb_q.push_back('{lsu: 1'b1, rdata: 32'hDEAD_BEEF});
        next_cycle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_1234);
        sample();
        checkOutput("t1_mem_req_c1", {31'd0, mem_req_o}, 32'd1);
        checkOutput("t1_mem_addr", mem_addr_o, 32'h1000_0000);
        checkOutput("t1_mem_we", {31'd0, mem_we_o}, 32'd0);
        next_cycle();
        sample();
        checkOutput("t1_mem_req_c2", {31'd0, mem_req_o}, 32'd1);
        next_cycle();
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hDEAD_BEEF;
        sample();
        checkOutput("t1_lsu_valid_c3", {31'd0, lsu_valid_o}, 32'd0);
        next_cycle();
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h5555_5555;
        sample();
        checkOutput("t1_lsu_valid_c4", {31'd0, lsu_valid_o}, 32'd1);
        checkOutput("t1_cache_valid_c4", {31'd0, cache_valid_o}, 32'd0);
        checkOutput("t1_mem_req_c4", {31'd0, mem_req_o}, 32'd0);

        // Simultaneous requests with rr at cache priority, immediate acks.
        next_cycle();
        applyStimulus(1'b1, 1'b0, 32'h0000_0100, '0, 1'b1, 1'b0, 32'h1000_0200, '0);
        sample();
        checkOutput("t2_cache_gnt", {31'd0, cache_gnt_o}, 32'd1);
        checkOutput("t2_lsu_gnt_c0", {31'd0, lsu_gnt_o}, 32'd0);
        sb_q.push_back('{lsu: 1'b0, rdata: 32'hA5A5_0001});
        next_cycle();
        cache_req_i = 1'b0;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hA5A5_0001;
        sample();
        checkOutput("t2_mem_addr_cache", mem_addr_o, 32'h0000_0100);
        checkOutput("t2_lsu_gnt_c1", {31'd0, lsu_gnt_o}, 32'd0);
        next_cycle();
        mem_ack_i = 1'b0;
        sample();
        checkOutput("t2_cache_valid_c2", {31'd0, cache_valid_o}, 32'd1);
        checkOutput("t2_lsu_gnt_c2", {31'd0, lsu_gnt_o}, 32'd0);
        next_cycle();
        sample();
        checkOutput("t2_lsu_gnt_c3", {31'd0, lsu_gnt_o}, 32'd1);
        sb_q.push_back('{lsu: 1'b1, rdata: 32'hA5A5_0002});
        next_cycle();
        lsu_req_i   = 1'b0;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hA5A5_0002;
        sample();
        checkOutput("t2_mem_addr_lsu", mem_addr_o, 32'h1000_0200);
        next_cycle();
        mem_ack_i = 1'b0;
        sample();
        checkOutput("t2_lsu_valid_c5", {31'd0, lsu_valid_o}, 32'd1);

        // Continuous contention: grants must alternate cache, LSU, cache, LSU.
        c_addr = 32'h0000_3000;
        l_addr = 32'h1000_3000;
        next_cycle();
        applyStimulus(1'b1, 1'b0, c_addr, '0, 1'b1, 1'b0, l_addr, '0);
        for (int i = 0; i < 4; i++) begin
            logic odd;
            odd = i[0];
            if (i > 0) next_cycle();
            sample();
            checkOutput($sformatf("t3_cache_gnt_%0d", i), {31'd0, cache_gnt_o}, {31'd0, ~odd});
            checkOutput($sformatf("t3_lsu_gnt_%0d", i), {31'd0, lsu_gnt_o}, {31'd0, odd});
            sb_q.push_back('{lsu: odd, rdata: 32'h3333_0000 + 32'(i)});
            next_cycle();
            mem_ack_i   = 1'b1;
            mem_rdata_i = 32'h3333_0000 + 32'(i);
            if (i == 3) applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
            sample();
            checkOutput($sformatf("t3_mem_addr_%0d", i), mem_addr_o, odd ? l_addr : c_addr);
            next_cycle();
            mem_ack_i = 1'b0;
            sample();
        end

        // LSU write with no ack: watchdog of 4 cycles.
        next_cycle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'h2000_0004, 32'h0000_00AA);
        sample();
        checkOutput("t4_lsu_gnt", {31'd0, lsu_gnt_o}, 32'd1);
        sb_q.push_back('{lsu: 1'b1, rdata: 32'd0});
        next_cycle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        sample();
        checkOutput("t4_mem_we", {31'd0, mem_we_o}, 32'd1);
        checkOutput("t4_mem_addr", mem_addr_o, 32'h2000_0004);
        checkOutput("t4_mem_wdata", mem_wdata_o, 32'h0000_00AA);
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) begin
                next_cycle();
                sample();
            end
            checkOutput($sformatf("t4_mem_req_c%0d", k), {31'd0, mem_req_o}, 32'd1);
            checkOutput($sformatf("t4_error_c%0d", k), {30'd0, error_o}, 32'd0);
        end
        next_cycle();
        sample();
        checkOutput("t4_mem_req_drop", {31'd0, mem_req_o}, 32'd0);
        checkOutput("t4_error_lsu", {30'd0, error_o}, 32'd2);
        checkOutput("t4_lsu_valid_early", {31'd0, lsu_valid_o}, 32'd0);
        next_cycle();
        sample();
        checkOutput("t4_lsu_valid", {31'd0, lsu_valid_o}, 32'd1);
        checkOutput("t4_error_after", {30'd0, error_o}, 32'd0);
        next_cycle();
        sample();
        checkOutput("t4_idle_mem_req", {31'd0, mem_req_o}, 32'd0);

        // Ack arriving exactly when the counter reaches the limit.
        next_cycle();
        applyStimulus(1'b1, 1'b0, 32'h0000_0400, '0, 1'b0, 1'b0, '0, '0);
        sample();
        checkOutput("t5_cache_gnt", {31'd0, cache_gnt_o}, 32'd1);
        sb_q.push_back('{lsu: 1'b0, rdata: 32'hCAFE_F00D});
        next_cycle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        sample();
        next_cycle();
        sample();
        next_cycle();
        sample();
        next_cycle();
        sample();
        checkOutput("t5_mem_req_c4", {31'd0, mem_req_o}, 32'd1);
        next_cycle();
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hCAFE_F00D;
        sample();
        checkOutput("t5_error_at_limit", {30'd0, error_o}, 32'd0);
        next_cycle();
        mem_ack_i = 1'b0;
        sample();
        checkOutput("t5_cache_valid", {31'd0, cache_valid_o}, 32'd1);
        checkOutput("t5_error_after", {30'd0, error_o}, 32'd0);

        // Reset during BUSY drops the transaction and restores rr to cache.
        next_cycle();
        applyStimulus(1'b1, 1'b0, 32'h0000_0500, '0, 1'b0, 1'b0, '0, '0);
        sample();
        checkOutput("t6_cache_gnt", {31'd0, cache_gnt_o}, 32'd1);
        next_cycle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        rstn_i = 1'b0;
        sample();
        next_cycle();
        rstn_i = 1'b1;
        sample();
        checkOutput("t6_mem_req", {31'd0, mem_req_o}, 32'd0);
        checkOutput("t6_mem_addr", mem_addr_o, 32'd0);
        checkOutput("t6_error", {30'd0, error_o}, 32'd0);
        checkOutput("t6_valids", {30'd0, cache_valid_o, lsu_valid_o}, 32'd0);
        next_cycle();
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h7777_7777;
        sample();
        next_cycle();
        mem_ack_i = 1'b0;
        sample();
        checkOutput("t6_stray_ack_mem_req", {31'd0, mem_req_o}, 32'd0);
        next_cycle();
        applyStimulus(1'b1, 1'b0, 32'h0000_0600, '0, 1'b1, 1'b0, 32'h1000_0600, '0);
        sample();
        checkOutput("t6_rr_cache_gnt", {31'd0, cache_gnt_o}, 32'd1);
        checkOutput("t6_rr_lsu_gnt", {31'd0, lsu_gnt_o}, 32'd0);
        sb_q.push_back('{lsu: 1'b0, rdata: 32'h0BAD_F00D});
        next_cycle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h0BAD_F00D;
        sample();
        checkOutput("t6_mem_addr_new", mem_addr_o, 32'h0000_0600);
        next_cycle();
        mem_ack_i = 1'b0;
        sample();
        checkOutput("t6_cache_valid", {31'd0, cache_valid_o}, 32'd1);

        next_cycle();
        sample();
        next_cycle();
        sample();
        checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
